connect4_game_ctrl: RTL

- Game-state engine that produces the board, cursor, turn and result consumed by the VGA panel display.
- Takes four debounced, synchronized button levels (left, right, drop, new game) and moves a column cursor.
- Drops tokens into the lowest free row, checks for a four-in-a-row win or a 42-move draw, and alternates players.
- All outputs are registered and stay stable between moves, so the display samples them asynchronously to its pixel scan.

---
 rtl/connect4_pkg.sv | 45 ++++
 rtl/connect4_game_ctrl_line_counter.sv | 52 +++++
 rtl/connect4_game_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 game controller.
// Board geometry, cell/winner/state encodings and small board helpers.
package connect4_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int WIN_LEN   = 4;
  localparam int MAX_MOVES = 42;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    P0_WIN = 2'b01,
    P1_WIN = 2'b10,
    DRAW   = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    PLAY, DROP, CHECK, RESOLVE, OVER
  } state_t;

  typedef cell_t [ROWS-1:0][COLS-1:0] board_t;

  function automatic board_t empty_board();
    board_t b;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b[r][c] = EMPTY;
    return b;
  endfunction

  function automatic cell_t colour_of(input logic p);
    return p ? P1 : P0;
  endfunction

  function automatic logic in_board(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

endpackage

// File: rtl/connect4_game_ctrl_line_counter.sv
// Counts same-colour runs from an origin cell along one direction.
// Ports: board_i, row_i/col_i origin, dir_i (0 H,1 V,2 UR,3 UL), colour_i; pos_o/neg_o run lengths (max 3).
module line_counter
  import connect4_pkg::*;
(
  input  board_t      board_i,
  input  logic [2:0]  row_i,
  input  logic [2:0]  col_i,
  input  logic [1:0]  dir_i,
  input  cell_t       colour_i,
  output logic [1:0]  pos_o,
  output logic [1:0]  neg_o
);

  int   dr, dc, r, c;
  logic run_p, run_n;

  always_comb begin
    dr = 0;
    dc = 0;
    case (dir_i)
      2'd0:    dc = 1;
      2'd1:    dr = 1;
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    pos_o = '0;
    neg_o = '0;
    run_p = 1'b1;
    run_n = 1'b1;
    r = 0;
    c = 0;
    // A run stops at the first foreign cell or board edge.
    for (int k = 1; k < WIN_LEN; k++) begin
      r = int'(row_i) + k * dr;
      c = int'(col_i) + k * dc;
      if (run_p && in_board(r, c) &&
          board_i[r[2:0]][c[2:0]] == colour_i)
        pos_o = pos_o + 2'd1;
      else
        run_p = 1'b0;
      r = int'(row_i) - k * dr;
      c = int'(col_i) - k * dc;
      if (run_n && in_board(r, c) &&
          board_i[r[2:0]][c[2:0]] == colour_i)
        neg_o = neg_o + 2'd1;
      else
        run_n = 1'b0;
    end
  end

endmodule

// File: rtl/connect4_game_ctrl.sv
// Connect-4 game-state engine: cursor, drops, win/draw detection, turns.
// Ports: clk, rst, btn_* levels in; panel, play, player, winner, busy out.
module connect4_game_ctrl
  import connect4_pkg::*;
#(
  parameter logic START_PLAYER = 1'b0,
  parameter int   WRAP_CURSOR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_drop,
  input  logic                  btn_new,
  output logic [5:0][6:0][1:0]  panel,
  output logic [6:0]            play,
  output logic                  player,
  output logic [1:0]            winner,
  output logic                  busy
);

  localparam logic [2:0] COL_MID = 3'(COLS / 2);
  localparam logic [2:0] COL_MAX = 3'(COLS - 1);
  localparam logic [2:0] EDGE_L  = (WRAP_CURSOR != 0) ? COL_MAX : 3'd0;
  localparam logic [2:0] EDGE_R  = (WRAP_CURSOR != 0) ? 3'd0 : COL_MAX;

  logic [3:0] prev_q, ev_q;
  logic       ev_left, ev_right, ev_drop, ev_new;

  state_t     state_q, state_d;
  board_t     board_q, board_d;
  logic [2:0] col_q, col_d;
  logic [6:0] play_q, play_d;
  logic       player_q, player_d;
  winner_t    winner_q, winner_d;
  logic [5:0] moves_q, moves_d;
  logic [2:0] last_r_q, last_r_d;
  logic [2:0] last_c_q, last_c_d;
  logic [1:0] dir_q, dir_d;
  logic       hit_q, hit_d;
  logic       pend_q, pend_d;
  logic       busy_q, busy_d;

  logic [2:0] free_r;
  logic       free_ok;
  logic [1:0] run_pos, run_neg;
  logic       run_hit;
  logic       idle;

  // Events are registered so a press acts one cycle after it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      ev_q   <= '0;
    end else begin
      prev_q <= {btn_new, btn_drop, btn_right, btn_left};
      ev_q   <= {btn_new, btn_drop, btn_right, btn_left} & ~prev_q;
    end
  end

  assign ev_left  = ev_q[0];
  assign ev_right = ev_q[1];
  assign ev_drop  = ev_q[2];
  assign ev_new   = ev_q[3];

  always_comb begin
    free_r  = '0;
    free_ok = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (!free_ok && board_q[r][col_q] == EMPTY) begin
        free_r  = 3'(r);
        free_ok = 1'b1;
      end
    end
  end

  line_counter u_line (
    .board_i  (board_q),
    .row_i    (last_r_q),
    .col_i    (last_c_q),
    .dir_i    (dir_q),
    .colour_i (colour_of(player_q)),
    .pos_o    (run_pos),
    .neg_o    (run_neg)
  );

  assign run_hit = ({1'b0, run_pos} + {1'b0, run_neg} + 3'd1)
                   >= 3'(WIN_LEN);
  assign idle = (state_q == PLAY) || (state_q == OVER);

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    col_d    = col_q;
    player_d = player_q;
    winner_d = winner_q;
    moves_d  = moves_q;
    last_r_d = last_r_q;
    last_c_d = last_c_q;
    dir_d    = dir_q;
    hit_d    = hit_q;
    pend_d   = pend_q;
    if (!idle)
      pend_d = pend_q | ev_new;
    if (idle && (ev_new || pend_q)) begin
      state_d  = PLAY;
      board_d  = empty_board();
      col_d    = COL_MID;
      player_d = START_PLAYER;
      winner_d = NONE;
      moves_d  = '0;
      hit_d    = 1'b0;
      pend_d   = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (ev_drop) begin
            if (board_q[ROWS-1][col_q] == EMPTY)
              state_d = DROP;
          end else if (ev_left && !ev_right) begin
            col_d = (col_q == 3'd0) ? EDGE_L : col_q - 3'd1;
          end else if (ev_right && !ev_left) begin
            col_d = (col_q == COL_MAX) ? EDGE_R : col_q + 3'd1;
          end
        end
        DROP: begin
          board_d[free_r][col_q] = colour_of(player_q);
          last_r_d = free_r;
          last_c_d = col_q;
          moves_d  = moves_q + 6'd1;
          dir_d    = 2'd0;
          hit_d    = 1'b0;
          state_d  = CHECK;
        end
        CHECK: begin
          hit_d = hit_q | run_hit;
          dir_d = dir_q + 2'd1;
          if (dir_q == 2'd3)
            state_d = RESOLVE;
        end
        RESOLVE: begin
          if (hit_q) begin
            winner_d = player_q ? P1_WIN : P0_WIN;
            state_d  = OVER;
          end else if (moves_q == 6'(MAX_MOVES)) begin
            winner_d = DRAW;
            state_d  = OVER;
          end else begin
            player_d = ~player_q;
            state_d  = PLAY;
          end
        end
        OVER: ;
        default: state_d = PLAY;
      endcase
    end
    play_d = 7'd1 << col_d;
    busy_d = (state_d == DROP) || (state_d == CHECK) ||
             (state_d == RESOLVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      board_q  <= empty_board();
      col_q    <= COL_MID;
      play_q   <= 7'b0001000;
      player_q <= START_PLAYER;
      winner_q <= NONE;
      moves_q  <= '0;
      last_r_q <= '0;
      last_c_q <= '0;
      dir_q    <= '0;
      hit_q    <= 1'b0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      col_q    <= col_d;
      play_q   <= play_d;
      player_q <= player_d;
      winner_q <= winner_d;
      moves_q  <= moves_d;
      last_r_q <= last_r_d;
      last_c_q <= last_c_d;
      dir_q    <= dir_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
    end
  end

  assign panel  = board_q;
  assign play   = play_q;
  assign player = player_q;
  assign winner = winner_q;
  assign busy   = busy_q;

endmodule
